// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PC addresses, issues one outstanding read to
// instruction memory, buffers returned words in a small FIFO and hands them to
// decode tagged with their fetch address. FLUSH discards buffered and in-flight
// fetches.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PC_out,
  input  logic              PC_VALID,
  output logic              PC_READY,
  input  logic              FLUSH,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              IR_VALID,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  input  logic              IR_READY,
  output logic              MISALIGN
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              misalign_q, misalign_d;

  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [ADDR_W-1:0] buf_addr_q [DEPTH];

  logic full;
  logic accept;
  logic aligned;
  logic push;
  logic pop;

  // Handshake qualifiers; FLUSH overrides accept, push and pop.
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    // Slot availability uses start-of-cycle count: no IR_READY -> PC_READY path.
    PC_READY = RESET && (state_q == StIdle) && !full && !FLUSH;
    accept   = PC_VALID && PC_READY;
    aligned  = (PC_out[1:0] == 2'b00);
    IR_VALID = (count_q != '0);
    pop      = IR_VALID && IR_READY && !FLUSH;
    push     = (state_q == StWait) && MEM_RVALID && !drop_q && !FLUSH;
  end

  // Fetch FSM next-state: idle -> request -> wait for response.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    mem_addr_d = mem_addr_q;
    misalign_d = accept && !aligned;
    unique case (state_q)
      StIdle: begin
        if (accept && aligned) begin
          mem_addr_d = PC_out;
          state_d    = StReq;
        end
      end
      StReq: begin
        // Request is never withdrawn; a flush only marks the response for discard.
        if (FLUSH) drop_d = 1'b1;
        if (MEM_GNT) state_d = StWait;
      end
      StWait: begin
        if (MEM_RVALID) begin
          // Response consumed here, so any pending discard is done.
          drop_d  = 1'b0;
          state_d = StIdle;
        end else if (FLUSH) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (FLUSH) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      drop_q     <= 1'b0;
      mem_addr_q <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      mem_addr_q <= mem_addr_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage; cleared on reset so IR/IR_PC read zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_data_q[i] <= '0;
        buf_addr_q[i] <= '0;
      end
    end else if (push) begin
      buf_data_q[wr_ptr_q] <= MEM_RDATA;
      buf_addr_q[wr_ptr_q] <= mem_addr_q;
    end
  end

  // Output drive.
  always_comb begin
    MEM_REQ  = (state_q == StReq);
    MEM_ADDR = mem_addr_q;
    IR       = buf_data_q[rd_ptr_q];
    IR_PC    = buf_addr_q[rd_ptr_q];
    MISALIGN = misalign_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, flush,
// stalled grant with flush, misalignment and mid-transaction reset.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [ADDR_W-1:0] PC_out;
  logic              PC_VALID;
  logic              PC_READY;
  logic              FLUSH;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_GNT;
  logic              MEM_RVALID;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              IR_VALID;
  logic [DATA_W-1:0] IR;
  logic [ADDR_W-1:0] IR_PC;
  logic              IR_READY;
  logic              MISALIGN;

  int compared   = 0;
  int mismatched = 0;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PC_out    (PC_out),
    .PC_VALID  (PC_VALID),
    .PC_READY  (PC_READY),
    .FLUSH     (FLUSH),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_GNT   (MEM_GNT),
    .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA (MEM_RDATA),
    .IR_VALID  (IR_VALID),
    .IR        (IR),
    .IR_PC     (IR_PC),
    .IR_READY  (IR_READY),
    .MISALIGN  (MISALIGN)
  );

  always #5 CLK = ~CLK;

  // A response while the buffer is full would overflow it.
  always @(posedge CLK) begin
    if (RESET && MEM_RVALID && (dut.count_q == DEPTH)) begin
      mismatched++;
      $error("FAIL overflow: response observed=1 with full buffer, required=0");
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One zero-wait fetch: accept, grant, respond. Returns sampled after the push edge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    PC_out   = addr;
    PC_VALID = 1'b1;
    chk("fetch_pc_ready", {31'd0, PC_READY}, 32'd1);
    step();
    PC_VALID = 1'b0;
    chk("fetch_req", {31'd0, MEM_REQ}, 32'd1);
    chk("fetch_addr", MEM_ADDR, addr);
    MEM_GNT = 1'b1;
    step();
    MEM_GNT = 1'b0;
    chk("fetch_req_drop", {31'd0, MEM_REQ}, 32'd0);
    MEM_RVALID = 1'b1;
    MEM_RDATA  = data;
    step();
    MEM_RVALID = 1'b0;
  endtask

  initial begin
    RESET      = 1'b0;
    PC_out     = '0;
    PC_VALID   = 1'b0;
    FLUSH      = 1'b0;
    MEM_GNT    = 1'b0;
    MEM_RVALID = 1'b0;
    MEM_RDATA  = '0;
    IR_READY   = 1'b0;
    #2;
    chk("rst_ir_valid", {31'd0, IR_VALID}, 32'd0);
    chk("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
    chk("rst_pc_ready", {31'd0, PC_READY}, 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'd0);
    chk("rst_ir", IR, 32'd0);
    chk("rst_ir_pc", IR_PC, 32'd0);
    chk("rst_misalign", {31'd0, MISALIGN}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    step();

    // Streaming with zero-wait memory.
    IR_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4), 32'(i * 4) ^ 32'hDEAD0000);
      chk("stream_valid", {31'd0, IR_VALID}, 32'd1);
      chk("stream_ir", IR, 32'hDEAD0000 + 32'(i * 4));
      chk("stream_ir_pc", IR_PC, 32'(i * 4));
    end
    step();
    chk("stream_drained", {31'd0, IR_VALID}, 32'd0);

    // Backpressure.
    IR_READY = 1'b0;
    fetch(32'h10, 32'hA0000010);
    fetch(32'h14, 32'hA0000014);
    PC_out   = 32'h18;
    PC_VALID = 1'b1;
    chk("bp_full_pc_ready", {31'd0, PC_READY}, 32'd0);
    chk("bp_head_pc", IR_PC, 32'h10);
    chk("bp_head_ir", IR, 32'hA0000010);
    IR_READY = 1'b1;
    chk("bp_no_comb_ready", {31'd0, PC_READY}, 32'd0);
    step();
    chk("bp_no_accept", {31'd0, MEM_REQ}, 32'd0);
    chk("bp_second_pc", IR_PC, 32'h14);
    chk("bp_second_ir", IR, 32'hA0000014);
    PC_VALID = 1'b0;
    step();
    chk("bp_empty", {31'd0, IR_VALID}, 32'd0);

    // Flush while waiting, one entry buffered.
    IR_READY = 1'b0;
    fetch(32'h30, 32'hB0000030);
    PC_out   = 32'h20;
    PC_VALID = 1'b1;
    step();
    PC_VALID = 1'b0;
    MEM_GNT  = 1'b1;
    step();
    MEM_GNT = 1'b0;
    FLUSH   = 1'b1;
    chk("fl_pc_ready", {31'd0, PC_READY}, 32'd0);
    step();
    FLUSH = 1'b0;
    chk("fl_emptied", {31'd0, IR_VALID}, 32'd0);
    step();
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'hB0000020;
    step();
    MEM_RVALID = 1'b0;
    chk("fl_dropped", {31'd0, IR_VALID}, 32'd0);
    chk("fl_idle_ready", {31'd0, PC_READY}, 32'd1);
    IR_READY = 1'b1;
    fetch(32'h40, 32'hB0000040);
    chk("fl_next_valid", {31'd0, IR_VALID}, 32'd1);
    chk("fl_next_pc", IR_PC, 32'h40);
    chk("fl_next_ir", IR, 32'hB0000040);
    step();

    // Stalled grant with flush in the second stall cycle.
    PC_out   = 32'h50;
    PC_VALID = 1'b1;
    step();
    PC_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      FLUSH = (i == 1);
      chk("st_req_held", {31'd0, MEM_REQ}, 32'd1);
      chk("st_addr_held", MEM_ADDR, 32'h50);
      step();
    end
    FLUSH   = 1'b0;
    MEM_GNT = 1'b1;
    chk("st_req_at_gnt", {31'd0, MEM_REQ}, 32'd1);
    step();
    MEM_GNT    = 1'b0;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'hC0000050;
    chk("st_wait_req", {31'd0, MEM_REQ}, 32'd0);
    step();
    MEM_RVALID = 1'b0;
    chk("st_dropped", {31'd0, IR_VALID}, 32'd0);
    fetch(32'h54, 32'hC0000054);
    chk("st_next_pc", IR_PC, 32'h54);
    step();

    // Misaligned address.
    IR_READY = 1'b0;
    fetch(32'h60, 32'hD0000060);
    PC_out   = 32'h6;
    PC_VALID = 1'b1;
    chk("mis_ready", {31'd0, PC_READY}, 32'd1);
    step();
    PC_VALID = 1'b0;
    chk("mis_pulse", {31'd0, MISALIGN}, 32'd1);
    chk("mis_no_req", {31'd0, MEM_REQ}, 32'd0);
    chk("mis_buf_pc", IR_PC, 32'h60);
    step();
    chk("mis_pulse_end", {31'd0, MISALIGN}, 32'd0);
    chk("mis_no_req2", {31'd0, MEM_REQ}, 32'd0);
    chk("mis_buf_valid", {31'd0, IR_VALID}, 32'd1);
    chk("mis_buf_pc2", IR_PC, 32'h60);

    // Reset in the middle of a wait with one entry buffered.
    PC_out   = 32'h74;
    PC_VALID = 1'b1;
    step();
    PC_VALID = 1'b0;
    MEM_GNT  = 1'b1;
    step();
    MEM_GNT    = 1'b0;
    PC_out     = 32'h78;
    PC_VALID   = 1'b1;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'hE0000074;
    #2;
    RESET = 1'b0;
    #1;
    chk("mrst_ir_valid", {31'd0, IR_VALID}, 32'd0);
    chk("mrst_mem_req", {31'd0, MEM_REQ}, 32'd0);
    chk("mrst_pc_ready", {31'd0, PC_READY}, 32'd0);
    chk("mrst_ir_pc", IR_PC, 32'd0);
    PC_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    step();
    MEM_RVALID = 1'b0;
    chk("mrst_late_rvalid", {31'd0, IR_VALID}, 32'd0);
    IR_READY = 1'b1;
    fetch(32'h0, 32'hDEAD0000);
    chk("mrst_first_valid", {31'd0, IR_VALID}, 32'd1);
    chk("mrst_first_pc", IR_PC, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
